// File: rtl/partial_force_writeback_buffer.sv
// partial_force_writeback_buffer: queues partial forces and issues them one at a time as retried write requests
// Optional macro FORCE_WB_STALL_CNT_EN enables the saturating retry counter on stall_cycles_o.
// Ports:
//   clk, rst                      clock; synchronous active-low reset
//   in_force_i/in_dst_i           producer entry {particle_id, fz, fy, fx} and destination select
//   in_valid_i/in_ready_o         producer handshake; ready while the FIFO is not full
//   force_data_o/force_valid_o    registered {head force, head dst} and one-cycle write request
//   force_cache_write_success_i   grant for the request issued in the previous cycle
//   buffer_empty_o                FIFO empty and no entry in flight
//   stall_cycles_o                consecutive failed attempts for the current head
module partial_force_writeback_buffer #(
    parameter int DATA_WIDTH         = 32,
    parameter int PARTICLE_ID_WIDTH  = 7,
    parameter int FORCE_DATA_WIDTH   = 3*DATA_WIDTH+PARTICLE_ID_WIDTH,
    parameter int FORCE_BUFFER_WIDTH = FORCE_DATA_WIDTH+1,
    parameter int FIFO_DEPTH         = 16,
    parameter int FIFO_ADDR_WIDTH    = 4,
    parameter int STALL_CNT_WIDTH    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [FORCE_DATA_WIDTH-1:0]   in_force_i,
    input  logic                          in_dst_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    output logic [FORCE_BUFFER_WIDTH-1:0] force_data_o,
    output logic                          force_valid_o,
    input  logic                          force_cache_write_success_i,
    output logic                          buffer_empty_o,
    output logic [STALL_CNT_WIDTH-1:0]    stall_cycles_o
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
    localparam logic [FIFO_ADDR_WIDTH:0] FULL = (FIFO_ADDR_WIDTH+1)'(FIFO_DEPTH);
    logic [FORCE_BUFFER_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [FORCE_BUFFER_WIDTH-1:0] force_data_q;
    logic                          force_valid_q;
    state_t                        state_q;
    logic [FIFO_ADDR_WIDTH-1:0]    wr_ptr_q, rd_ptr_q, rd_next;
    logic [FIFO_ADDR_WIDTH:0]      count_q, count_d;
    logic                          push, pop;
    assign in_ready_o     = count_q != FULL;
    assign push           = in_valid_i & in_ready_o;
    assign pop            = (state_q == S_WAIT) & force_cache_write_success_i;
    assign rd_next        = rd_ptr_q + FIFO_ADDR_WIDTH'(1);
    assign count_d        = count_q + (FIFO_ADDR_WIDTH+1)'(push) - (FIFO_ADDR_WIDTH+1)'(pop);
    assign buffer_empty_o = (count_q == '0) && (state_q == S_IDLE);
    assign force_data_o   = force_data_q;
    assign force_valid_o  = force_valid_q;
    always_ff @(posedge clk) begin
        if (rst && push) mem_q[wr_ptr_q] <= {in_force_i, in_dst_i};
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            force_data_q  <= '0;
            force_valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + FIFO_ADDR_WIDTH'(1);
            if (pop) rd_ptr_q <= rd_next;
            case (state_q)
                S_IDLE: if (count_q != '0) begin
                    force_data_q  <= mem_q[rd_ptr_q];
                    force_valid_q <= 1'b1;
                    state_q       <= S_REQ;
                end
                S_REQ: begin
                    force_valid_q <= 1'b0;
                    state_q       <= S_WAIT;
                end
                S_WAIT: begin
                    // A failed grant retries the same head; a success with another entry
                    // queued loads it directly so service stays at two cycles per entry.
                    if (!force_cache_write_success_i || count_q > (FIFO_ADDR_WIDTH+1)'(1)) begin
                        if (force_cache_write_success_i) force_data_q <= mem_q[rd_next];
                        force_valid_q <= 1'b1;
                        state_q       <= S_REQ;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    force_valid_q <= 1'b0;
                    state_q       <= S_IDLE;
                end
            endcase
        end
    end
`ifdef FORCE_WB_STALL_CNT_EN
    logic [STALL_CNT_WIDTH-1:0] stall_q;
    always_ff @(posedge clk) begin
        if (!rst || pop) stall_q <= '0;
        else if (state_q == S_WAIT && stall_q != '1) stall_q <= stall_q + STALL_CNT_WIDTH'(1);
    end
    assign stall_cycles_o = stall_q;
`else
    assign stall_cycles_o = '0;
`endif
endmodule

// File: tb/tb_partial_force_writeback_buffer.sv
// tb_partial_force_writeback_buffer: table vectors plus scoreboard sequences for the writeback buffer
module tb_partial_force_writeback_buffer;
    localparam int FDW = 103;
    localparam int FBW = 104;
    localparam int SW  = 8;
    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [FDW-1:0] in_force = '0;
    logic           in_dst = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [FBW-1:0] force_data;
    logic           force_valid;
    logic           success = 1'b0;
    logic           buffer_empty;
    logic [SW-1:0]  stall_cycles;
    always #5 clk = ~clk;
    partial_force_writeback_buffer dut (
        .clk                         (clk),
        .rst                         (rst),
        .in_force_i                  (in_force),
        .in_dst_i                    (in_dst),
        .in_valid_i                  (in_valid),
        .in_ready_o                  (in_ready),
        .force_data_o                (force_data),
        .force_valid_o               (force_valid),
        .force_cache_write_success_i (success),
        .buffer_empty_o              (buffer_empty),
        .stall_cycles_o              (stall_cycles)
    );
    typedef struct {
        logic           v;
        logic [FDW-1:0] f;
        logic           d;
        logic           s;
        logic           e_fv;
        logic [FBW-1:0] e_data;
        logic           e_empty;
        logic           e_ready;
        logic [SW-1:0]  e_stall;
    } vec_t;
    vec_t           vec[$];
    logic [FBW-1:0] sb[$];
    int n_cmp = 0;
    int n_bad = 0;
    int pops = 0;
    int reqs = 0;
    int grant_pct = 100;
    bit wait_now = 0;
    bit last_fv = 0;
    bit auto_grant = 0;
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    function automatic logic [SW-1:0] st(input int n);
`ifdef FORCE_WB_STALL_CNT_EN
        return SW'(n);
`else
        return SW'(n * 0);
`endif
    endfunction
    function automatic vec_t mk(input logic v, input logic [FDW-1:0] f, input logic d, input logic s,
                                input logic fv, input logic [FBW-1:0] data, input logic empty,
                                input logic ready, input logic [SW-1:0] stall);
        mk = '{v, f, d, s, fv, data, empty, ready, stall};
    endfunction
    // One clock of scoreboard-driven operation: records the transfer at the edge,
    // checks any request against the queue head, and answers a WAIT cycle with a grant.
    task automatic tick();
        bit pushed, popped;
        pushed = in_valid && in_ready;
        popped = success && wait_now;
        @(posedge clk); #1;
        if (pushed) sb.push_back({in_force, in_dst});
        if (popped) begin
            if (sb.size() > 0) void'(sb.pop_front());
            pops++;
        end
        wait_now = last_fv;
        last_fv  = force_valid;
        if (force_valid) begin
            reqs++;
            if (sb.size() == 0) chk("req_on_empty", force_valid, 0);
            else chk("req_data", force_data, sb[0]);
        end
        success = wait_now && auto_grant && ($urandom_range(99) < grant_pct);
    endtask
    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        success = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        wait_now = 0;
        last_fv = 0;
        pops = 0;
        reqs = 0;
    endtask
    task automatic drain();
        in_valid = 1'b0;
        auto_grant = 1;
        for (int k = 0; k < 600 && !(buffer_empty && sb.size() == 0); k++) tick();
    endtask
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        logic [FDW-1:0] f1, f2;
        int np;
        f1 = {7'd5, 32'hC0000000, 32'h40000000, 32'h3F800000};
        f2 = {7'd9, 32'h11111111, 32'h22222222, 32'h33333333};
        // reset with a dropped in_valid
        rst = 1'b0;
        in_valid = 1'b1;
        in_force = f2;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        chk("rst_fv", force_valid, 0);
        chk("rst_data", force_data, 0);
        chk("rst_empty", buffer_empty, 1);
        chk("rst_ready", in_ready, 1);
        chk("rst_stall", stall_cycles, 0);
        repeat (3) tick();
        chk("rst_drop_reqs", reqs, 0);
        chk("rst_drop_empty", buffer_empty, 1);
        // cycle-exact vectors: single entry, spurious grants in IDLE/REQ, three withheld grants
        vec.push_back(mk(1, f1, 1, 0, 0, '0,         0, 1, st(0)));
        vec.push_back(mk(0, '0, 0, 1, 1, {f1, 1'b1}, 0, 1, st(0)));
        vec.push_back(mk(0, '0, 0, 1, 0, {f1, 1'b1}, 0, 1, st(0)));
        vec.push_back(mk(0, '0, 0, 1, 0, {f1, 1'b1}, 1, 1, st(0)));
        vec.push_back(mk(0, '0, 0, 0, 0, {f1, 1'b1}, 1, 1, st(0)));
        vec.push_back(mk(1, f2, 0, 0, 0, {f1, 1'b1}, 0, 1, st(0)));
        vec.push_back(mk(0, '0, 0, 0, 1, {f2, 1'b0}, 0, 1, st(0)));
        vec.push_back(mk(0, '0, 0, 0, 0, {f2, 1'b0}, 0, 1, st(0)));
        vec.push_back(mk(0, '0, 0, 0, 1, {f2, 1'b0}, 0, 1, st(1)));
        vec.push_back(mk(0, '0, 0, 0, 0, {f2, 1'b0}, 0, 1, st(1)));
        vec.push_back(mk(0, '0, 0, 0, 1, {f2, 1'b0}, 0, 1, st(2)));
        vec.push_back(mk(0, '0, 0, 0, 0, {f2, 1'b0}, 0, 1, st(2)));
        vec.push_back(mk(0, '0, 0, 0, 1, {f2, 1'b0}, 0, 1, st(3)));
        vec.push_back(mk(0, '0, 0, 0, 0, {f2, 1'b0}, 0, 1, st(3)));
        vec.push_back(mk(0, '0, 0, 1, 0, {f2, 1'b0}, 1, 1, st(0)));
        for (int i = 0; i < vec.size(); i++) begin
            in_valid = vec[i].v;
            in_force = vec[i].f;
            in_dst   = vec[i].d;
            success  = vec[i].s;
            @(posedge clk); #1;
            chk($sformatf("row%0d_fv", i), force_valid, vec[i].e_fv);
            chk($sformatf("row%0d_data", i), force_data, vec[i].e_data);
            chk($sformatf("row%0d_empty", i), buffer_empty, vec[i].e_empty);
            chk($sformatf("row%0d_ready", i), in_ready, vec[i].e_ready);
            chk($sformatf("row%0d_stall", i), stall_cycles, vec[i].e_stall);
        end
        // fill to 16 without grants, offer a 17th, then drain in order
        do_reset();
        auto_grant = 0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_force = {7'(i + 20), $urandom(), $urandom(), $urandom()};
            in_dst = i[0];
            tick();
        end
        chk("full_ready", in_ready, 0);
        in_force = {7'd99, $urandom(), $urandom(), $urandom()};
        repeat (4) tick();
        chk("full_hold_ready", in_ready, 0);
        drain();
        chk("fill_pops", pops, 16);
        chk("fill_empty", buffer_empty, 1);
        // random streaming with partial grants, 100 entries
        do_reset();
        auto_grant = 1;
        grant_pct = 70;
        np = 0;
        for (int k = 0; k < 3000 && np < 100; k++) begin
            in_valid = ($urandom_range(2) == 0);
            in_force = {7'(np), $urandom(), $urandom(), $urandom()};
            in_dst = 1'($urandom_range(1));
            if (in_valid && in_ready) np++;
            tick();
        end
        chk("stream_pushed", np, 100);
        drain();
        grant_pct = 100;
        chk("stream_pops", pops, 100);
        chk("stream_sb", sb.size(), 0);
        chk("stream_empty", buffer_empty, 1);
        // reset while in WAIT with five entries queued
        do_reset();
        auto_grant = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_force = {7'(i + 40), $urandom(), $urandom(), $urandom()};
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 10 && !force_valid; k++) tick();
        chk("pre_rst_req", force_valid, 1);
        tick();
        rst = 1'b0;
        success = 1'b1;
        @(posedge clk); #1;
        chk("midrst_fv", force_valid, 0);
        chk("midrst_data", force_data, 0);
        chk("midrst_empty", buffer_empty, 1);
        chk("midrst_ready", in_ready, 1);
        chk("midrst_stall", stall_cycles, 0);
        rst = 1'b1;
        sb.delete();
        wait_now = 0;
        last_fv = 0;
        reqs = 0;
        pops = 0;
        success = 1'b1;
        tick();
        repeat (10) tick();
        chk("post_rst_reqs", reqs, 0);
        chk("post_rst_empty", buffer_empty, 1);
        in_valid = 1'b1;
        in_force = f1;
        in_dst = 1'b1;
        tick();
        drain();
        chk("post_rst_pops", pops, 1);
        chk("post_rst_reqs2", reqs, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
